hus_parm_bank: RTL
==================

// Module: hus_parm_bank
// PURPOSE
//  Multi-channel HUS parameter bank and timebase: latches per-channel 32-bit reload values and global
//  sample/tick rates from Z80 byte writes, generates sample_stb/tick_stb, and commits reloads on tick.
//  Sits between the zports/fmaps write decode and the HUS channel engines; replaces single-set latching.
// PARAMETERS
//  CHANNELS  4   number of reload channels (1..8)
//  ADDR_W    5   write address width; must cover 4*CHANNELS+3 locations
// PORTS
//  clk          in   1            system clock
//  rst_n        in   1            asynchronous reset, active low
//  en           in   1            timebase enable; 0 holds counters at 0, no strobes
//  wr_stb       in   1            one-cycle byte write strobe
//  wr_addr      in   ADDR_W       register address (map below)
//  zdata        in   8            write data from fmaps
//  rd_addr      in   ADDR_W       readback address (used only with HUS_PARM_RDBK_EN)
//  rd_data      out  8            readback data
//  sample_stb   out  1            one-cycle pulse per sample period
//  tick_stb     out  1            one-cycle pulse per tick period, coincident with a sample_stb
//  reload       out  32*CHANNELS  committed reload per channel, ch n at [32n+31:32n]
//  reload_vld   out  CHANNELS     one-cycle pulse, cycle after commit, per channel committed
// BEHAVIOUR
//  Map: addr 4c+b (c<CHANNELS, b=0..3) = shadow reload[c] byte b; 4*CHANNELS = sample_rate;
//   4*CHANNELS+1 = tick_rate[7:0]; 4*CHANNELS+2 = tick_rate[9:8] (zdata[1:0]); others ignored.
//  Reset: all shadows, active rates, counters, reload, reload_vld, strobes, pend flags = 0.
//  Reload write: byte stored in shadow same edge; write to byte 3 sets pend[c]. Bytes 0..2 alone never commit.
//  Commit on tick_stb edge: per c, reload[c] <= pend[c] ? shadow[c] : 0; pend[c] cleared;
//   reload_vld[c] pulses next cycle for committed channels only. Non-pending channels read 0 for that tick.
//  Simultaneous byte-3 write and tick_stb: shadow updated, pend[c] stays set, commit deferred to next tick
//   (old shadow is NOT committed that edge; reload[c] <= 0 unless it was already pending -> old value commits).
//  Sample prescaler: scnt counts clk; scnt==sr_act -> scnt<=0, sample_stb=1 (period sr_act+1 clocks;
//   sr_act=0 -> stb every clock). Strobe is registered: asserted cycle after match.
//  Tick counter: tcnt counts sample_stb; tcnt==tr_act at a sample_stb -> tcnt<=0, tick_stb with that sample_stb.
//  Rate shadows: sr_act/tr_act load from shadows only at own counter wrap or while en=0; mid-period
//   writes never shorten/extend the running period. tick_rate lo/hi bytes update shadow independently.
//  en falling: scnt,tcnt <=0, strobes 0 next cycle; pend and shadows retained. en rising: first sample_stb
//   after sr_act+1 clocks.
//  Reset mid-operation: everything returns to reset values immediately; pending writes lost.
//  Widths: counters 8/10 bit, compare exact equality, no overflow possible as cnt<=rate.
// CONFIGURATION
//  HUS_PARM_RDBK_EN defined: rd_data combinationally returns shadow byte / sample_rate / tick_rate byte
//   (hi byte zero-extended) at rd_addr; unmapped -> 8'hFF. Undefined: rd_data tied 8'hFF, no read mux.
// TESTING
//  T1 reset, en=1, sample_rate=3, tick_rate=1 -> sample_stb every 4 clk, tick_stb every 8 clk.
//  T2 write ch2 bytes 0..3 = 78,56,34,12 -> next tick reload[2]=0x12345678, reload_vld=4'b0100; next tick reload[2]=0.
//  T3 byte-3 write to ch0 same cycle as tick_stb -> reload[0]=0 that tick, 0x.. value commits on following tick.
//  T4 sample_rate 3->9 written mid-period -> current period stays 4 clk, next periods 10 clk.
//  T5 en=0 for 20 clk with pend[1] set -> no strobes; after en=1 commit happens on first tick_stb.
//  T6 RDBK_EN: write 4*CH+2 = 0xFF -> rd_data at that addr = 0x03; unmapped addr -> 0xFF.

Source files
------------

// File: rtl/hus_parm_bank.sv
// hus_parm_bank: multi-channel HUS reload bank and sample/tick timebase.
// Latches per-channel 32-bit reloads and global sample/tick rates from
// Z80 byte writes, generates sample_stb/tick_stb, commits reloads on tick.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   en                    timebase enable (0 holds counters at 0)
//   wr_stb/wr_addr/zdata  byte write port
//   rd_addr/rd_data       readback (mux present only with HUS_PARM_RDBK_EN)
//   sample_stb/tick_stb   registered timebase strobes
//   reload/reload_vld     committed reloads (ch n at [32n+31:32n]) and pulses
// Config macro: HUS_PARM_RDBK_EN enables the readback mux; otherwise rd_data=8'hFF.
module hus_parm_bank #(
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   wr_stb,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [7:0]             zdata,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [7:0]             rd_data,
    output logic                   sample_stb,
    output logic                   tick_stb,
    output logic [32*CHANNELS-1:0] reload,
    output logic [CHANNELS-1:0]    reload_vld
);

    localparam logic [ADDR_W-1:0] A_SR  = ADDR_W'(4*CHANNELS);
    localparam logic [ADDR_W-1:0] A_TRL = ADDR_W'(4*CHANNELS+1);
    localparam logic [ADDR_W-1:0] A_TRH = ADDR_W'(4*CHANNELS+2);

    logic [CHANNELS-1:0][31:0] shadow;
    logic [CHANNELS-1:0][31:0] rel_q;
    logic [CHANNELS-1:0]       pend;
    logic [CHANNELS-1:0]       vld_q;
    logic [CHANNELS-1:0]       b3_wr;

    logic [7:0] sr_sh;
    logic [7:0] sr_act;
    logic [7:0] scnt;
    logic [9:0] tr_sh;
    logic [9:0] tr_act;
    logic [9:0] tcnt;
    logic       s_q;
    logic       t_q;
    logic       s_wrap;
    logic       t_wrap;

    assign s_wrap = en && (scnt == sr_act);
    assign t_wrap = s_wrap && (tcnt == tr_act);

    always_comb begin
        b3_wr = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            b3_wr[c] = wr_stb && (wr_addr == ADDR_W'(4*c+3));
        end
    end

    // Timebase; active rates only change at their own wrap or while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt   <= '0;
            tcnt   <= '0;
            s_q    <= 1'b0;
            t_q    <= 1'b0;
            sr_act <= '0;
            tr_act <= '0;
        end else begin
            if (!en) begin
                scnt <= '0;
                tcnt <= '0;
                s_q  <= 1'b0;
                t_q  <= 1'b0;
            end else begin
                s_q  <= s_wrap;
                t_q  <= t_wrap;
                scnt <= s_wrap ? 8'd0 : scnt + 8'd1;
                if (s_wrap) begin
                    tcnt <= t_wrap ? 10'd0 : tcnt + 10'd1;
                end
            end
            if (!en || s_wrap) begin
                sr_act <= sr_sh;
            end
            if (!en || t_wrap) begin
                tr_act <= tr_sh;
            end
        end
    end

    // Shadow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            sr_sh  <= '0;
            tr_sh  <= '0;
        end else if (wr_stb) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_addr == ADDR_W'(4*c+b)) begin
                        shadow[c][8*b +: 8] <= zdata;
                    end
                end
            end
            if (wr_addr == A_SR) begin
                sr_sh <= zdata;
            end
            if (wr_addr == A_TRL) begin
                tr_sh[7:0] <= zdata;
            end
            if (wr_addr == A_TRH) begin
                tr_sh[9:8] <= zdata[1:0];
            end
        end
    end

    // Commit: the pre-edge shadow commits only if already pending;
    // a byte-3 write landing on the tick edge defers to the next tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rel_q <= '0;
            vld_q <= '0;
            pend  <= '0;
        end else if (t_q) begin
            for (int c = 0; c < CHANNELS; c++) begin
                rel_q[c] <= pend[c] ? shadow[c] : 32'd0;
            end
            vld_q <= pend;
            pend  <= b3_wr;
        end else begin
            vld_q <= '0;
            pend  <= pend | b3_wr;
        end
    end

    assign sample_stb = s_q;
    assign tick_stb   = t_q;
    assign reload     = rel_q;
    assign reload_vld = vld_q;

`ifdef HUS_PARM_RDBK_EN
    always_comb begin
        rd_data = 8'hFF;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int b = 0; b < 4; b++) begin
                if (rd_addr == ADDR_W'(4*c+b)) begin
                    rd_data = shadow[c][8*b +: 8];
                end
            end
        end
        if (rd_addr == A_SR) begin
            rd_data = sr_sh;
        end
        if (rd_addr == A_TRL) begin
            rd_data = tr_sh[7:0];
        end
        if (rd_addr == A_TRH) begin
            rd_data = {6'd0, tr_sh[9:8]};
        end
    end
`else
    logic unused_rd;
    assign unused_rd = ^rd_addr;
    assign rd_data   = 8'hFF;
`endif

endmodule
